// File: rtl/sdram_bist_pkg.sv
// Shared types and constants for the SDRAM built-in self test.
// The LFSR step is a right-shifting Galois form of x^32+x^22+x^2+x+1.
package sdram_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_WAIT,
    RD_REQ,
    RD_WAIT,
    FINISH
  } state_e;

  localparam logic [1:0] PAT_ADDR  = 2'd0;
  localparam logic [1:0] PAT_NADDR = 2'd1;
  localparam logic [1:0] PAT_LFSR  = 2'd2;
  localparam logic [1:0] PAT_CONST = 2'd3;

  localparam logic [31:0] LFSR_SEED     = 32'hACE1_2468;
  localparam logic [31:0] LFSR_POLY     = 32'h8020_0003;
  localparam logic [31:0] CONST_PATTERN = 32'hA5A5_5A5A;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/sdram_bist_lfsr.sv
// 32-bit pattern LFSR: load reseeds, advance steps once; load wins.
module sdram_bist_lfsr
  import sdram_bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        advance,
  output logic [31:0] value
);

  logic [31:0] value_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
    end else if (load) begin
      value_q <= LFSR_SEED;
    end else if (advance) begin
      value_q <= lfsr_step(value_q);
    end
  end

  assign value = value_q;

endmodule

// File: rtl/sdram_bist.sv
// Write-then-read memory test over a word range with one transaction in flight.
// Status outputs describe the most recent run and hold until the next start.
module sdram_bist
  import sdram_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [23:0]           num_words,
  input  logic [1:0]            pattern_sel,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [DATA_WIDTH-1:0] first_err_data,
  output logic [3:0]            ctrl_wr,
  output logic                  ctrl_rd,
  output logic [ADDR_WIDTH-1:0] ctrl_addr,
  output logic [DATA_WIDTH-1:0] ctrl_write_data,
  input  logic                  ctrl_rdy,
  input  logic                  ctrl_wvalid,
  input  logic                  ctrl_rvalid,
  input  logic [DATA_WIDTH-1:0] ctrl_read_data,
  input  logic                  ctrl_error
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] base_q, addr_q, ferr_addr_q;
  logic [DATA_WIDTH-1:0] ferr_data_q;
  logic [23:0]           nwords_q, idx_q;
  logic [1:0]            pat_q;
  logic [WAIT_W-1:0]     wait_q;
  logic [15:0]           err_q, err_d;
  logic                  busy_q, done_q, pass_q, timeout_q, wr_q, rd_q;

  logic [ADDR_WIDTH-1:0] base_aligned;
  logic [DATA_WIDTH-1:0] exp_data;
  logic [31:0]           lfsr_val;
  logic                  last_word, wr_done, rd_done, mismatch, wait_expired;
  logic                  lfsr_load, lfsr_adv;

  assign base_aligned = base_addr & ~ADDR_WIDTH'(3);
  assign last_word    = (idx_q == nwords_q - 24'd1);
  assign wr_done      = (state_q == WR_WAIT) && ctrl_wvalid;
  assign rd_done      = (state_q == RD_WAIT) && ctrl_rvalid;
  assign mismatch     = (ctrl_read_data != exp_data) || ctrl_error;
  assign wait_expired = (wait_q == WAIT_W'(TIMEOUT - 1));
  assign err_d        = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;

  // The read phase replays the write sequence, so the LFSR reseeds at the turnaround.
  assign lfsr_load = ((state_q == IDLE) && start) || (wr_done && last_word);
  assign lfsr_adv  = wr_done || rd_done;

  sdram_bist_lfsr u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .value   (lfsr_val)
  );

  always_comb begin
    exp_data = DATA_WIDTH'(CONST_PATTERN);
    case (pat_q)
      PAT_ADDR:  exp_data = DATA_WIDTH'(addr_q);
      PAT_NADDR: exp_data = DATA_WIDTH'(~addr_q);
      PAT_LFSR:  exp_data = DATA_WIDTH'(lfsr_val);
      default:   exp_data = DATA_WIDTH'(CONST_PATTERN);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      addr_q      <= '0;
      nwords_q    <= '0;
      idx_q       <= '0;
      pat_q       <= '0;
      wait_q      <= '0;
      err_q       <= '0;
      ferr_addr_q <= '0;
      ferr_data_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            base_q      <= base_aligned;
            addr_q      <= base_aligned;
            nwords_q    <= num_words;
            pat_q       <= pattern_sel;
            idx_q       <= '0;
            err_q       <= '0;
            ferr_addr_q <= '0;
            ferr_data_q <= '0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b1;
            if (num_words == 24'd0) begin
              state_q <= FINISH;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
            end else begin
              state_q <= WR_REQ;
              wr_q    <= 1'b1;
              pass_q  <= 1'b0;
            end
          end
        end
        WR_REQ: begin
          if (ctrl_rdy) begin
            wr_q    <= 1'b0;
            wait_q  <= '0;
            state_q <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (ctrl_wvalid) begin
            if (last_word) begin
              idx_q   <= '0;
              addr_q  <= base_q;
              rd_q    <= 1'b1;
              state_q <= RD_REQ;
            end else begin
              idx_q   <= idx_q + 24'd1;
              addr_q  <= addr_q + ADDR_WIDTH'(4);
              wr_q    <= 1'b1;
              state_q <= WR_REQ;
            end
          end else if (wait_expired) begin
            timeout_q <= 1'b1;
            pass_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= FINISH;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        RD_REQ: begin
          if (ctrl_rdy) begin
            rd_q    <= 1'b0;
            wait_q  <= '0;
            state_q <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (ctrl_rvalid) begin
            if (mismatch) begin
              err_q <= err_d;
              if (err_q == 16'd0) begin
                ferr_addr_q <= addr_q;
                ferr_data_q <= ctrl_read_data;
              end
            end
            if (last_word) begin
              pass_q  <= !mismatch && (err_q == 16'd0);
              done_q  <= 1'b1;
              state_q <= FINISH;
            end else begin
              idx_q   <= idx_q + 24'd1;
              addr_q  <= addr_q + ADDR_WIDTH'(4);
              rd_q    <= 1'b1;
              state_q <= RD_REQ;
            end
          end else if (wait_expired) begin
            timeout_q <= 1'b1;
            pass_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= FINISH;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        FINISH: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          wr_q    <= 1'b0;
          rd_q    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign timeout         = timeout_q;
  assign err_count       = err_q;
  assign first_err_addr  = ferr_addr_q;
  assign first_err_data  = ferr_data_q;
  assign ctrl_wr         = {4{wr_q}};
  assign ctrl_rd         = rd_q;
  assign ctrl_addr       = addr_q;
  assign ctrl_write_data = wr_q ? exp_data : '0;

endmodule
